nibble_serial_add_ctrl: RTL and testbench

- Multi-cycle sequencer that performs a WIDTH-bit add by time-multiplexing one external SLICE-bit ripple-carry adder slice, one nibble per cycle, LSB first.
- Sits directly around the adder slice: drives the slice's A/B/Cin and consumes its S/Cout.
- Registers the inter-slice carry, assembles the full sum, and returns it with carry-out and signed overflow.
- Operand intake and result return each use a valid/ready handshake.

---
 rtl/nibble_serial_add_ctrl_if.sv | 30 +++
 rtl/nibble_serial_add_ctrl.sv | 119 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// nibble_serial_add_ctrl_if : operand-intake / result-return handshake bundle
// Rev 1.0
// ============================================================================
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_serial_add_ctrl : WIDTH-bit add sequenced through one external
// SLICE-bit adder slice, LSB slice first.  Rev 1.0
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    nibble_serial_add_ctrl_if.slave bus,
    output logic [SLICE-1:0]      slice_a_o,
    output logic [SLICE-1:0]      slice_b_o,
    output logic                  slice_cin_o,
    input  wire logic [SLICE-1:0] slice_s_i,
    input  wire logic             slice_cout_i
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             w_accept;
    logic             w_last;
    logic             w_ovf;

    assign w_accept = (state_q == S_IDLE) && bus.in_valid && in_ready_q;
    assign w_last   = (idx_q == IDXW'(NSLICE - 1));
    // Overflow: operands share a sign and the result's sign differs from it.
    assign w_ovf    = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (slice_s_i[SLICE-1] ^ a_q[WIDTH-1]);

    // Slice drive is only live in RUN so the shared adder sees zeros otherwise.
    always_comb begin
        slice_a_o   = '0;
        slice_b_o   = '0;
        slice_cin_o = 1'b0;
        if (state_q == S_RUN) begin
            slice_a_o   = a_q[idx_q*SLICE +: SLICE];
            slice_b_o   = b_q[idx_q*SLICE +: SLICE];
            slice_cin_o = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[idx_q*SLICE +: SLICE] <= slice_s_i;
                    carry_q <= slice_cout_i;
                    idx_q   <= idx_q + IDXW'(1);
                    if (w_last) begin
                        cout_q      <= slice_cout_i;
                        ovf_q       <= w_ovf;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nibble_serial_add_ctrl : directed + randomized checks against an
// arithmetic reference model, with an ideal adder slice. Rev 1.0
// ============================================================================
module tb_nibble_serial_add_ctrl;
    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk;
    logic             rst_n;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic             slice_cin;
    logic [SLICE-1:0] slice_s;
    logic             slice_cout;

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_add_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .slice_a_o    (slice_a),
        .slice_b_o    (slice_b),
        .slice_cin_o  (slice_cin),
        .slice_s_i    (slice_s),
        .slice_cout_i (slice_cout)
    );

    // Ideal external adder slice
    assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer addition.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic c);
        longint unsigned full;
        logic [WIDTH-1:0] s;
        logic co, ov;
        full = longint'(x) + longint'(y) + longint'(c);
        s    = full[WIDTH-1:0];
        co   = full[WIDTH];
        ov   = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        return {ov, co, s};
    endfunction

    function automatic logic [SLICE-1:0] nib(input logic [WIDTH-1:0] x, input int i);
        logic [WIDTH-1:0] t;
        t = x >> (i * SLICE);
        return t[SLICE-1:0];
    endfunction

    // Carry entering slice i = carry out of the low i*SLICE bits of the add.
    function automatic logic carry_into(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                        input logic c, input int i);
        longint unsigned m, t;
        if (i == 0) return c;
        m = (64'd1 << (i * SLICE)) - 1;
        t = (longint'(x) & m) + (longint'(y) & m) + longint'(c);
        return t[i*SLICE];
    endfunction

    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tc, input int hold);
        logic [WIDTH+1:0] exp;
        int cyc;
        bit got;
        exp = ref_add(ta, tb, tc);
        @(negedge clk);
        bus.a = ta; bus.b = tb; bus.cin = tc; bus.in_valid = 1'b1;
        check_eq("in_ready_idle", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
        cyc = 0; got = 0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) got = 1;
            else if (cyc <= NSLICE) begin
                check_eq("slice_a", slice_a, nib(ta, cyc - 1));
                check_eq("slice_b", slice_b, nib(tb, cyc - 1));
                check_eq("slice_cin", slice_cin, carry_into(ta, tb, tc, cyc - 1));
                check_eq("in_ready_run", bus.in_ready, 0);
            end
        end
        check_eq("latency", got ? cyc : 0, NSLICE + 1);
        if (!got) return;
        check_eq("result", {bus.ovf, bus.cout, bus.sum}, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_in_ready", bus.in_ready, 0);
            check_eq("hold_result", {bus.ovf, bus.cout, bus.sum}, exp);
            check_eq("hold_slice_a", slice_a, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("ret_valid_low", bus.out_valid, 0);
        check_eq("ret_in_ready", bus.in_ready, 1);
        check_eq("idle_result_kept", {bus.ovf, bus.cout, bus.sum}, exp);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);   // RUN with idx == 2
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_sum", bus.sum, 0);
        check_eq("rst_cout", bus.cout, 0);
        check_eq("rst_ovf", bus.ovf, 0);
        check_eq("rst_slice", {slice_cin, slice_b, slice_a}, 0);
        repeat (2) @(negedge clk);
        check_eq("rst_hold_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rel_in_ready", bus.in_ready, 1);
        check_eq("rst_rel_valid", bus.out_valid, 0);
        run_add(16'h0001, 16'h0001, 1'b0, 0);
    endtask

    task automatic back_to_back(input int n_ops);
        logic [WIDTH+1:0] exp_q[$];
        int accepts, results, cyc, last_acc;
        bit pending;
        accepts = 0; results = 0; cyc = 0; last_acc = -100; pending = 1;
        bus.out_ready = 1'b1;
        while (cyc < 40 * n_ops && results < n_ops) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
                pending = 0;
            end
            bus.in_valid = (accepts < n_ops);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) check_eq("b2b_spurious", 1, 0);
                else check_eq("b2b_result", {bus.ovf, bus.cout, bus.sum}, exp_q.pop_front());
                results++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_add(bus.a, bus.b, bus.cin));
                if (accepts > 0) check_eq("b2b_spacing_ok", (cyc - last_acc) >= NSLICE + 2, 1);
                last_acc = cyc;
                accepts++;
                pending = 1;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("b2b_count", results, n_ops);
        check_eq("b2b_leftover", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_valid", bus.out_valid, 0);
        check_eq("reset_result", {bus.ovf, bus.cout, bus.sum}, 0);
        check_eq("reset_slice", {slice_cin, slice_b, slice_a}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_in_ready", bus.in_ready, 1);

        run_add(16'h1234, 16'h4321, 1'b0, 5);
        run_add(16'h000F, 16'h0000, 1'b1, 0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 1);
        run_add(16'h7FFF, 16'h0001, 1'b0, 0);
        run_add(16'h8000, 16'h8000, 1'b0, 2);
        run_add(16'hFFFF, 16'hFFFF, 1'b0, 0);
        reset_mid_run();
        for (int i = 0; i < 16; i++)
            run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
        back_to_back(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
